chip8_mem_arbiter: RTL and testbench
====================================

Name: chip8_mem_arbiter

Overview:
- Shares the single 4 KB CHIP-8 memory port between three requesters: the program loader (writes), the CPU fetch/execute path (reads), and the sprite fetch unit used by DXYN (burst reads).
- Sits between `chip8_cpu`, the sprite engine, the ROM loader and the memory macro.
- Loader has strict priority. CPU and sprite share the port round-robin.
- Sprite may lock the port for bounded bursts.

Parameters:
- ADDR_W, 12, memory address width.
- DATA_W, 8, memory data width.
- MAX_BURST, 16, max consecutive locked sprite grants before a pending CPU request is served (range 1..255).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- ld_req  in  1  loader write request.
- ld_addr  in  ADDR_W  loader write address.
- ld_wdata  in  DATA_W  loader write data.
- ld_gnt  out  1  loader granted this cycle (write performed at this edge).
- cpu_req  in  1  CPU read request.
- cpu_addr  in  ADDR_W  CPU read address.
- cpu_gnt  out  1  CPU granted this cycle.
- cpu_rvalid  out  1  rdata holds the CPU's data this cycle.
- spr_req  in  1  sprite read request.
- spr_lock  in  1  sprite requests port retention for next beat.
- spr_addr  in  ADDR_W  sprite read address.
- spr_gnt  out  1  sprite granted this cycle.
- spr_rvalid  out  1  rdata holds the sprite's data this cycle.
- rdata  out  DATA_W  read data, equals mem_rdata.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after read strobe.
- busy  out  1  any grant or rvalid active.

Behaviour:
- **Reset:**
  - While reset=1, force all gnt, rvalid, mem_en, mem_we and busy to 0, and mem_addr and mem_wdata to 0.
  - Set rr_ptr to CPU-favoured, burst_cnt to 0 and the rvalid pipeline to 0.
  - A read granted in the cycle before reset produces no rvalid.
- **Grant (combinational from registered state and current req):**
  - Priority 1: ld_req. Grant the loader.
  - Priority 2: spr_req with lock_active, where lock_active = previous cycle was a locked sprite grant AND NOT (burst_cnt==MAX_BURST AND cpu_req).
  - Priority 3: cpu_req and spr_req both high. Grant the requester favoured by rr_ptr.
  - Priority 4: the single requester that is asserting req.
- At most one gnt per cycle. With no request, mem_en=0.
- **Memory drive:**
  - mem_en=1 when any grant is active.
  - mem_we=1 only on a loader grant.
  - mem_addr and mem_wdata come from the granted requester. mem_wdata=0 on reads.
- **Read latency:**
  - A grant at cycle t raises the matching rvalid at t+1 (registered), with rdata=mem_rdata.
  - Requesters may change addr/req at t+1. Back-to-back grants give one rvalid per cycle.
- **rr_ptr:**
  - After a CPU grant, favour sprite. After a sprite grant, favour CPU.
  - A loader grant leaves rr_ptr unchanged.
- **burst_cnt:**
  - Increment (saturate at MAX_BURST) on each sprite grant with spr_lock=1.
  - Clear on any CPU grant, on a sprite grant with spr_lock=0, or on an idle cycle.
  - Loader cycles neither count nor clear it, and a lock survives loader preemption.
  - If MAX_BURST is reached and cpu_req=0, the sprite keeps the port; the count stays saturated.
- spr_lock without spr_req is ignored, and lock_active clears.
- Requests are level-sensitive. A requester holds req until it sees gnt. No queuing inside the arbiter.
- busy = |{gnt} | |{rvalid}.

Test Plan:
- Reset → hold reset 3 cycles with all req=1 → all gnt, rvalid, mem_en = 0; first cycle after release grants ld.
- CPU alone: cpu_req=1, cpu_addr=0x200, memory[0x200]=0xA2 → cpu_gnt=1, mem_en=1, mem_we=0, mem_addr=0x200 at t; cpu_rvalid=1, rdata=0xA2 at t+1.
- CPU and sprite both constantly requesting, spr_lock=0, from reset → grants cpu,spr,cpu,spr,…; rvalid alternates one cycle later.
- MAX_BURST=4, sprite locked, cpu_req held high → spr_gnt 4 cycles, cpu_gnt 1 cycle, spr_gnt 4 more; with cpu_req=0, spr_gnt continues indefinitely.
- Loader write (ld_addr=0x300, ld_wdata=0x5C) mid locked sprite burst → ld_gnt=1, mem_we=1, spr_gnt=0 that cycle; sprite burst resumes next cycle with burst_cnt unchanged; a later CPU read of 0x300 returns 0x5C.
- CPU granted at t, reset asserted at t+1 → cpu_rvalid=0 at t+1 and after, until a new grant.

Source files
------------

// File: rtl/chip8_mem_arbiter.sv
// Shares the CHIP-8 memory port: loader first, CPU and sprite round-robin, with bounded locked sprite bursts.
// Grants are combinational from registered state; read data returns one cycle after the grant.
module chip8_mem_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  input  logic              spr_req,
  input  logic              spr_lock,
  input  logic [ADDR_W-1:0] spr_addr,
  output logic              spr_gnt,
  output logic              spr_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_BURST);

  typedef enum logic {FAV_CPU, FAV_SPR} rr_t;

  rr_t        rr_ptr;
  logic [7:0] burst_cnt;
  logic       lock_q;
  logic       cpu_rv_q;
  logic       spr_rv_q;
  logic       lock_active;

  // A saturated burst only yields when the CPU is actually waiting.
  assign lock_active = lock_q && !((burst_cnt == MAX_CNT) && cpu_req);

  always_comb begin
    ld_gnt  = 1'b0;
    cpu_gnt = 1'b0;
    spr_gnt = 1'b0;
    if (!reset) begin
      if (ld_req) begin
        ld_gnt = 1'b1;
      end else if (spr_req && lock_active) begin
        spr_gnt = 1'b1;
      end else if (cpu_req && spr_req) begin
        if (rr_ptr == FAV_CPU) cpu_gnt = 1'b1;
        else                   spr_gnt = 1'b1;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (spr_req) begin
        spr_gnt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= FAV_CPU;
      burst_cnt <= 8'd0;
      lock_q    <= 1'b0;
      cpu_rv_q  <= 1'b0;
      spr_rv_q  <= 1'b0;
    end else begin
      cpu_rv_q <= cpu_gnt;
      spr_rv_q <= spr_gnt;
      if (cpu_gnt) begin
        rr_ptr    <= FAV_SPR;
        burst_cnt <= 8'd0;
        lock_q    <= 1'b0;
      end else if (spr_gnt) begin
        rr_ptr <= FAV_CPU;
        if (spr_lock) begin
          lock_q <= 1'b1;
          if (burst_cnt != MAX_CNT) burst_cnt <= burst_cnt + 8'd1;
        end else begin
          lock_q    <= 1'b0;
          burst_cnt <= 8'd0;
        end
      end else if (!ld_gnt) begin
        // Idle cycle ends any burst; loader cycles leave lock state intact.
        lock_q    <= 1'b0;
        burst_cnt <= 8'd0;
      end
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (ld_gnt) begin
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
    end else if (cpu_gnt) begin
      mem_addr = cpu_addr;
    end else if (spr_gnt) begin
      mem_addr = spr_addr;
    end
  end

  // Masking with reset drops a read whose grant landed just before reset.
  assign cpu_rvalid = cpu_rv_q && !reset;
  assign spr_rvalid = spr_rv_q && !reset;
  assign mem_en     = ld_gnt || cpu_gnt || spr_gnt;
  assign mem_we     = ld_gnt;
  assign rdata      = mem_rdata;
  assign busy       = mem_en || cpu_rvalid || spr_rvalid;

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Directed vector bench for chip8_mem_arbiter with MAX_BURST=4 and a behavioural memory.
module tb_chip8_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ld_req = 1'b0, cpu_req = 1'b0, spr_req = 1'b0, spr_lock = 1'b0;
  logic [11:0] ld_addr = '0, cpu_addr = '0, spr_addr = 12'h050;
  logic [7:0]  ld_wdata = '0;
  logic        ld_gnt, cpu_gnt, cpu_rvalid, spr_gnt, spr_rvalid;
  logic [7:0]  rdata, mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic        mem_en, mem_we, busy;
  logic [11:0] mem_addr;

  logic [7:0] mem [4096];

  int checks = 0;
  int errors = 0;

  chip8_mem_arbiter #(.ADDR_W(12), .DATA_W(8), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .spr_req(spr_req), .spr_lock(spr_lock), .spr_addr(spr_addr), .spr_gnt(spr_gnt),
    .spr_rvalid(spr_rvalid), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  typedef struct {
    logic       rst, ld, cpu, spr, lock;
    logic [11:0] ld_addr;
    logic [7:0]  ld_wdata;
    logic [11:0] cpu_addr;
    logic [2:0]  gnt;   // {ld, cpu, spr}
    logic [1:0]  rv;    // {cpu, spr}
    logic [7:0]  rd;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, ld, cpu, spr, lock,
                              input logic [11:0] la, input logic [7:0] lw,
                              input logic [11:0] ca,
                              input logic [2:0] g, input logic [1:0] rv,
                              input logic [7:0] rd);
    vec_t v;
    v.rst = rst; v.ld = ld; v.cpu = cpu; v.spr = spr; v.lock = lock;
    v.ld_addr = la; v.ld_wdata = lw; v.cpu_addr = ca;
    v.gnt = g; v.rv = rv; v.rd = rd;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, got, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i);
    mem[12'h200] = 8'hA2;

    // reset held with every requester active
    add(1,1,1,1,1, 12'h300,8'h5C, 12'h200, 3'b000, 2'b00, 8'h00);
    add(1,1,1,1,1, 12'h300,8'h5C, 12'h200, 3'b000, 2'b00, 8'h00);
    add(1,1,1,1,1, 12'h300,8'h5C, 12'h200, 3'b000, 2'b00, 8'h00);
    add(0,1,1,1,1, 12'h300,8'h5C, 12'h200, 3'b100, 2'b00, 8'h00);
    // CPU alone, then idle
    add(0,0,1,0,0, 12'h300,8'h5C, 12'h200, 3'b010, 2'b00, 8'h00);
    add(0,0,0,0,0, 12'h300,8'h5C, 12'h200, 3'b000, 2'b10, 8'hA2);
    // round robin, unlocked
    add(0,0,1,1,0, 12'h300,8'h5C, 12'h300, 3'b001, 2'b00, 8'h00);
    add(0,0,1,1,0, 12'h300,8'h5C, 12'h300, 3'b010, 2'b01, 8'h50);
    add(0,0,1,1,0, 12'h300,8'h5C, 12'h300, 3'b001, 2'b10, 8'h5C);
    add(0,0,1,1,0, 12'h300,8'h5C, 12'h300, 3'b010, 2'b01, 8'h50);
    // locked burst of 4 against a waiting CPU
    add(0,0,1,1,1, 12'h300,8'h5C, 12'h300, 3'b001, 2'b10, 8'h5C);
    add(0,0,1,1,1, 12'h300,8'h5C, 12'h300, 3'b001, 2'b01, 8'h50);
    add(0,0,1,1,1, 12'h300,8'h5C, 12'h300, 3'b001, 2'b01, 8'h50);
    add(0,0,1,1,1, 12'h300,8'h5C, 12'h300, 3'b001, 2'b01, 8'h50);
    add(0,0,1,1,1, 12'h300,8'h5C, 12'h300, 3'b010, 2'b01, 8'h50);
    // second burst with a loader write after the third beat
    add(0,0,1,1,1, 12'h300,8'h5C, 12'h300, 3'b001, 2'b10, 8'h5C);
    add(0,0,1,1,1, 12'h300,8'h5C, 12'h300, 3'b001, 2'b01, 8'h50);
    add(0,0,1,1,1, 12'h300,8'h5C, 12'h300, 3'b001, 2'b01, 8'h50);
    add(0,1,1,1,1, 12'h310,8'h77, 12'h300, 3'b100, 2'b01, 8'h50);
    add(0,0,1,1,1, 12'h300,8'h5C, 12'h300, 3'b001, 2'b00, 8'h00);
    add(0,0,1,1,1, 12'h300,8'h5C, 12'h300, 3'b010, 2'b01, 8'h50);
    // no CPU demand: sprite keeps the port past saturation
    add(0,0,0,1,1, 12'h300,8'h5C, 12'h300, 3'b001, 2'b10, 8'h5C);
    add(0,0,0,1,1, 12'h300,8'h5C, 12'h300, 3'b001, 2'b01, 8'h50);
    add(0,0,0,1,1, 12'h300,8'h5C, 12'h300, 3'b001, 2'b01, 8'h50);
    add(0,0,0,1,1, 12'h300,8'h5C, 12'h300, 3'b001, 2'b01, 8'h50);
    add(0,0,0,1,1, 12'h300,8'h5C, 12'h300, 3'b001, 2'b01, 8'h50);
    add(0,0,0,1,1, 12'h300,8'h5C, 12'h300, 3'b001, 2'b01, 8'h50);
    add(0,0,1,1,1, 12'h300,8'h5C, 12'h300, 3'b010, 2'b01, 8'h50);
    // lock without request is ignored; read back loader data
    add(0,0,1,0,1, 12'h300,8'h5C, 12'h310, 3'b010, 2'b10, 8'h5C);
    add(0,0,0,0,0, 12'h300,8'h5C, 12'h310, 3'b000, 2'b10, 8'h77);
    // reset the cycle after a CPU grant
    add(0,0,1,0,0, 12'h300,8'h5C, 12'h200, 3'b010, 2'b00, 8'h00);
    add(1,0,1,0,0, 12'h300,8'h5C, 12'h200, 3'b000, 2'b00, 8'h00);
    add(0,0,0,0,0, 12'h300,8'h5C, 12'h200, 3'b000, 2'b00, 8'h00);
    add(0,0,1,1,0, 12'h300,8'h5C, 12'h200, 3'b010, 2'b00, 8'h00);
    add(0,0,0,0,0, 12'h300,8'h5C, 12'h200, 3'b000, 2'b10, 8'hA2);

    foreach (vecs[i]) begin
      logic        e_en, e_we, e_busy;
      logic [11:0] e_addr;
      logic [7:0]  e_wd;
      @(posedge clk);
      #1;
      reset    = vecs[i].rst;
      ld_req   = vecs[i].ld;
      cpu_req  = vecs[i].cpu;
      spr_req  = vecs[i].spr;
      spr_lock = vecs[i].lock;
      ld_addr  = vecs[i].ld_addr;
      ld_wdata = vecs[i].ld_wdata;
      cpu_addr = vecs[i].cpu_addr;
      #4;
      e_en   = |vecs[i].gnt;
      e_we   = vecs[i].gnt[2];
      e_busy = e_en | (|vecs[i].rv);
      e_addr = vecs[i].gnt[2] ? vecs[i].ld_addr :
               vecs[i].gnt[1] ? vecs[i].cpu_addr :
               vecs[i].gnt[0] ? 12'h050 : 12'h000;
      e_wd   = vecs[i].gnt[2] ? vecs[i].ld_wdata : 8'h00;
      check("gnt", i, {29'd0, ld_gnt, cpu_gnt, spr_gnt}, {29'd0, vecs[i].gnt});
      check("rvalid", i, {30'd0, cpu_rvalid, spr_rvalid}, {30'd0, vecs[i].rv});
      check("en_we_busy", i, {29'd0, mem_en, mem_we, busy}, {29'd0, e_en, e_we, e_busy});
      check("mem_addr", i, {20'd0, mem_addr}, {20'd0, e_addr});
      check("mem_wdata", i, {24'd0, mem_wdata}, {24'd0, e_wd});
      if (vecs[i].rv != 2'b00) check("rdata", i, {24'd0, rdata}, {24'd0, vecs[i].rd});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
